// File: rtl/sample_buffer.sv
// Two-channel capture buffer: arm, capture 2^DEPTH_LOG2 pairs, read out.
// Optional level trigger when SAMPLE_BUFFER_TRIG_EN is defined.
module sample_buffer #(
  parameter int DATA_W     = 14,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  fco,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_W-1:0]     din_a,
  input  logic [DATA_W-1:0]     din_b,
`ifdef SAMPLE_BUFFER_TRIG_EN
  input  logic [DATA_W-1:0]     trig_level,
`endif
  input  logic                  arm,
  input  logic                  rd_en,
  output logic [2*DATA_W-1:0]   rd_data,
  output logic                  rd_valid,
  output logic                  busy,
  output logic                  done,
  output logic [DEPTH_LOG2:0]   wr_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LAST =
    (DEPTH_LOG2+1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [2*DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH_LOG2:0] r_wr_count;
  logic [DEPTH_LOG2:0] r_rd_ptr;
  logic [2*DATA_W-1:0] r_rd_data;
  logic                r_rd_valid;

  logic w_trig;
  logic w_clr;
  logic w_wr;
  logic w_rd;
  logic w_wr_last;

  assign w_wr_last = (r_wr_count == LAST);

`ifdef SAMPLE_BUFFER_TRIG_EN
  // r_last_vld keeps the first sample after arm from forming a crossing
  logic [DATA_W-1:0] r_last_a;
  logic              r_last_vld;

  always_ff @(posedge fco) begin
    if (rst || w_clr) begin
      r_last_a   <= '0;
      r_last_vld <= 1'b0;
    end else if (load) begin
      r_last_a   <= din_a;
      r_last_vld <= 1'b1;
    end
  end

  assign w_trig = load && r_last_vld &&
                  (r_last_a < trig_level) &&
                  (trig_level <= din_a);
`else
  assign w_trig = load;
`endif

  always_ff @(posedge fco) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_clr  = 1'b0;
    w_wr   = 1'b0;
    w_rd   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (arm) begin
          w_next = S_ARMED;
          w_clr  = 1'b1;
        end
      end
      S_ARMED: begin
        if (w_trig) begin
          w_wr   = 1'b1;
          w_next = w_wr_last ? S_DONE : S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (load) begin
          w_wr = 1'b1;
          if (w_wr_last) w_next = S_DONE;
        end
      end
      S_DONE: begin
        if (arm) begin
          w_next = S_ARMED;
          w_clr  = 1'b1;
        end else if (rd_en && (r_rd_ptr < r_wr_count)) begin
          w_rd = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge fco) begin
    if (w_wr && !rst)
      r_mem[r_wr_count[DEPTH_LOG2-1:0]] <= {din_a, din_b};
  end

  always_ff @(posedge fco) begin
    if (rst) begin
      r_wr_count <= '0;
      r_rd_ptr   <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd;
      if (w_clr) begin
        r_wr_count <= '0;
        r_rd_ptr   <= '0;
      end else begin
        if (w_wr) r_wr_count <= r_wr_count + 1'b1;
        if (w_rd) begin
          r_rd_data <= r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];
          r_rd_ptr  <= r_rd_ptr + 1'b1;
        end
      end
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign wr_count = r_wr_count;
  assign busy     = (r_state == S_ARMED) ||
                    (r_state == S_CAPTURE);
  assign done     = (r_state == S_DONE);

endmodule

// File: tb/tb_sample_buffer.sv
// Bench for sample_buffer: read data checked by a queue-based monitor,
// status outputs checked inline after each stimulus cycle.
module tb_sample_buffer;

  localparam int DW = 14;
  localparam int DL = 4;

  logic            fco = 1'b0;
  logic            rst = 1'b1;
  logic            load = 1'b0;
  logic [DW-1:0]   din_a = '0;
  logic [DW-1:0]   din_b = '0;
  logic            arm = 1'b0;
  logic            rd_en = 1'b0;
  logic [2*DW-1:0] rd_data;
  logic            rd_valid;
  logic            busy;
  logic            done;
  logic [DL:0]     wr_count;
`ifdef SAMPLE_BUFFER_TRIG_EN
  logic [DW-1:0]   trig_level = 14'h2000;
`endif

  sample_buffer #(.DATA_W(DW), .DEPTH_LOG2(DL)) dut (
    .fco        (fco),
    .rst        (rst),
    .load       (load),
    .din_a      (din_a),
    .din_b      (din_b),
`ifdef SAMPLE_BUFFER_TRIG_EN
    .trig_level (trig_level),
`endif
    .arm        (arm),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .busy       (busy),
    .done       (done),
    .wr_count   (wr_count)
  );

  always #5 fco = ~fco;

  int n_cmp = 0;
  int n_bad = 0;
  logic [2*DW-1:0] exp_q [$];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge fco);
    #1;
  endtask

  initial begin : monitor
    logic [2*DW-1:0] e;
    forever begin
      @(negedge fco);
      if (rd_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rd_valid", 32'(rd_data), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("rd_data", 32'(rd_data), 32'(e));
        end
      end
    end
  end

  initial begin : stim
    int cnt;
    logic [DW-1:0] a;
    logic [DW-1:0] b;

    step();
    step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_wr_count", 32'(wr_count), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    rst = 1'b0;
    step();

    // full ramp capture
    arm = 1'b1;
    step();
    arm = 1'b0;
    chk("armed_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 16; k++) begin
      load  = 1'b1;
      din_a = DW'(k);
      din_b = DW'(14'h3FFF - k);
      step();
      chk("ramp_wr_count", 32'(wr_count), 32'(k + 1));
      chk("ramp_done", 32'(done), 32'(k == 15));
    end
    load = 1'b0;
    chk("ramp_busy_after", 32'(busy), 32'd0);
    for (int k = 0; k < 16; k++) begin
      rd_en = 1'b1;
      exp_q.push_back({DW'(k), DW'(14'h3FFF - k)});
      step();
    end
    rd_en = 1'b0;
    step();
    chk("idle_rd_valid", 32'(rd_valid), 32'd0);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("empty_rd_valid", 32'(rd_valid), 32'd0);
    chk("empty_rd_hold", 32'(rd_data), 32'({14'd15, 14'h3FF0}));

    // toggling load
    arm = 1'b1;
    step();
    arm = 1'b0;
    chk("rearm_wr_count", 32'(wr_count), 32'd0);
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      if (i % 2 == 0) begin
        load  = 1'b1;
        din_a = DW'((i / 2) * 3 + 1);
        din_b = DW'(i / 2) ^ 14'h2AAA;
        cnt++;
      end else begin
        load  = 1'b0;
        din_a = 14'h1555;
        din_b = 14'h0AAA;
      end
      step();
      chk("tog_wr_count", 32'(wr_count), 32'(cnt));
      chk("tog_done", 32'(done), 32'(cnt == 16));
    end
    load = 1'b0;
    for (int j = 0; j < 3; j++) begin
      rd_en = 1'b1;
      exp_q.push_back({DW'(j * 3 + 1), DW'(j) ^ 14'h2AAA});
      step();
    end
    arm   = 1'b1;
    rd_en = 1'b1;
    step();
    arm   = 1'b0;
    rd_en = 1'b0;
    chk("armrd_rd_valid", 32'(rd_valid), 32'd0);
    chk("armrd_wr_count", 32'(wr_count), 32'd0);
    chk("armrd_busy", 32'(busy), 32'd1);
    chk("armrd_done", 32'(done), 32'd0);

    // arm ignored in capture, then reset mid-capture
    for (int i = 0; i < 7; i++) begin
      load  = 1'b1;
      din_a = DW'(i + 100);
      din_b = DW'(i);
      arm   = (i == 4);
      step();
      chk("cap7_wr_count", 32'(wr_count), 32'(i + 1));
    end
    load = 1'b0;
    arm  = 1'b0;
    rst  = 1'b1;
    step();
    rst  = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_wr_count", 32'(wr_count), 32'd0);
    chk("midrst_rd_data", 32'(rd_data), 32'd0);
    rst   = 1'b1;
    arm   = 1'b1;
    load  = 1'b1;
    rd_en = 1'b1;
    step();
    rst  = 1'b0;
    arm  = 1'b0;
    load = 1'b0;
    chk("rstdom_busy", 32'(busy), 32'd0);
    chk("rstdom_wr_count", 32'(wr_count), 32'd0);
    step();
    rd_en = 1'b0;
    chk("idle_rd_en", 32'(rd_valid), 32'd0);

`ifdef SAMPLE_BUFFER_TRIG_EN
    arm = 1'b1;
    step();
    arm = 1'b0;
    load  = 1'b1;
    din_b = 14'h0111;
    din_a = 14'h1F00;
    step();
    chk("trig_1f00", 32'(wr_count), 32'd0);
    din_a = 14'h1FF0;
    step();
    chk("trig_1ff0", 32'(wr_count), 32'd0);
    din_a = 14'h2000;
    step();
    chk("trig_2000", 32'(wr_count), 32'd1);
    for (int k = 1; k < 16; k++) begin
      din_a = DW'(14'h2000 + k);
      step();
    end
    load = 1'b0;
    chk("trig_done", 32'(done), 32'd1);
    rd_en = 1'b1;
    exp_q.push_back({14'h2000, 14'h0111});
    step();
    rd_en = 1'b0;
    arm = 1'b1;
    step();
    arm = 1'b0;
    load  = 1'b1;
    din_a = 14'h2100;
    for (int k = 0; k < 5; k++) step();
    load = 1'b0;
    chk("flat_wr_count", 32'(wr_count), 32'd0);
    chk("flat_busy", 32'(busy), 32'd1);
`endif

    step();
    step();
    a = 14'd0;
    b = 14'd0;
    chk("queue_drained", 32'(exp_q.size()), 32'(a + b));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
